// File: rtl/flash_arbiter_pkg.sv
// ---- flash_arbiter_pkg : shared owner encoding and data widths for the flash arbiter ----
// ---- Rev 1.0 --------------------------------------------------------------------------
`default_nettype none

package flash_arbiter_pkg;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LPM  = 2'd2
  } owner_e;

  localparam int c_DATA_W = 16;
  localparam int c_BYTE_W = 8;

endpackage

`default_nettype wire

// File: rtl/flash_arbiter_if.sv
// ---- flash_arbiter_if : fetch, LPM and flash-side signals of the flash arbiter ----
// ---- Rev 1.0 ---------------------------------------------------------------------
`default_nettype none

interface flash_arbiter_if
  import flash_arbiter_pkg::*;
#(
  parameter int FLASH_WIDTH = 10
);

  logic                   if_req;
  logic [FLASH_WIDTH-1:0] if_addr;
  logic                   if_gnt;
  logic                   if_valid;
  logic [c_DATA_W-1:0]    if_data;

  logic                   lpm_req;
  logic [FLASH_WIDTH:0]   lpm_addr;
  logic                   lpm_gnt;
  logic                   lpm_valid;
  logic [c_BYTE_W-1:0]    lpm_data;

  logic                   mem_ce;
  logic [FLASH_WIDTH-1:0] mem_a;
  logic [c_DATA_W-1:0]    mem_d;

  modport slave (
    input  if_req, if_addr, lpm_req, lpm_addr, mem_d,
    output if_gnt, if_valid, if_data, lpm_gnt, lpm_valid, lpm_data, mem_ce, mem_a
  );

  modport master (
    output if_req, if_addr, lpm_req, lpm_addr, mem_d,
    input  if_gnt, if_valid, if_data, lpm_gnt, lpm_valid, lpm_data, mem_ce, mem_a
  );

endinterface

`default_nettype wire

// File: rtl/flash_arbiter.sv
// ---- flash_arbiter : shares the program flash between instruction fetch and LPM loads ----
// ---- Rev 1.0 ----------------------------------------------------------------------------
`default_nettype none

module flash_arbiter
  import flash_arbiter_pkg::*;
#(
  parameter int FLASH_WIDTH  = 10,
  parameter int STARVE_LIMIT = 3
) (
  input  wire logic        clk,
  input  wire logic        rst,
  flash_arbiter_if.slave   bus
);

  localparam int            c_CNT_W = (STARVE_LIMIT > 0) ? $clog2(STARVE_LIMIT + 1) : 1;

  owner_e               r_owner;
  owner_e               w_owner_nxt;
  logic                 r_byte_sel;
  logic                 w_byte_sel_nxt;
  logic [c_CNT_W-1:0]   r_starve_cnt;
  logic [c_CNT_W-1:0]   w_starve_nxt;
  logic                 w_force_if;
  logic                 w_if_gnt;
  logic                 w_lpm_gnt;

  generate
    if (STARVE_LIMIT == 0) begin : g_if_strict
      assign w_force_if = 1'b1;
    end else begin : g_if_starve
      localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);
      assign w_force_if = (r_starve_cnt >= c_LIMIT);
    end
  endgenerate

  // LPM wins by default; a starved fetch overrides it.
  assign w_lpm_gnt = bus.lpm_req & ~(bus.if_req & w_force_if);
  assign w_if_gnt  = bus.if_req & ~w_lpm_gnt;

  assign bus.if_gnt  = w_if_gnt;
  assign bus.lpm_gnt = w_lpm_gnt;
  assign bus.mem_ce  = w_if_gnt | w_lpm_gnt;
  assign bus.mem_a   = w_lpm_gnt ? bus.lpm_addr[FLASH_WIDTH:1] :
                       w_if_gnt  ? bus.if_addr : '0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_owner      <= OWN_NONE;
      r_byte_sel   <= 1'b0;
      r_starve_cnt <= '0;
    end else begin
      r_owner      <= w_owner_nxt;
      r_byte_sel   <= w_byte_sel_nxt;
      r_starve_cnt <= w_starve_nxt;
    end
  end

  always_comb begin
    w_owner_nxt    = OWN_NONE;
    w_byte_sel_nxt = r_byte_sel;
    w_starve_nxt   = '0;
    if (w_lpm_gnt) begin
      w_owner_nxt    = OWN_LPM;
      w_byte_sel_nxt = bus.lpm_addr[0];
    end else if (w_if_gnt) begin
      w_owner_nxt    = OWN_IF;
    end
    // A denied fetch is never forced, so holding at the limit is the saturation.
    if (bus.if_req && !w_if_gnt) begin
      w_starve_nxt = w_force_if ? r_starve_cnt : r_starve_cnt + 1'b1;
    end
  end

  assign bus.if_valid  = (r_owner == OWN_IF);
  assign bus.lpm_valid = (r_owner == OWN_LPM);
  assign bus.if_data   = bus.mem_d;
  assign bus.lpm_data  = r_byte_sel ? bus.mem_d[15:8] : bus.mem_d[7:0];

endmodule

`default_nettype wire

// File: tb/tb_flash_arbiter.sv
// ---- tb_flash_arbiter : directed self-checking bench for flash_arbiter ----
// ---- Rev 1.0 -------------------------------------------------------------
`default_nettype none

module tb_flash_arbiter;
  import flash_arbiter_pkg::*;

  localparam int c_FW = 10;

  logic clk;
  logic rst;
  int   n_vec;
  int   n_err;

  logic [15:0] flash [0:(1<<c_FW)-1];

  flash_arbiter_if #(.FLASH_WIDTH(c_FW)) bus0 ();
  flash_arbiter_if #(.FLASH_WIDTH(c_FW)) bus1 ();

  flash_arbiter #(.FLASH_WIDTH(c_FW), .STARVE_LIMIT(3)) dut0 (
    .clk (clk),
    .rst (rst),
    .bus (bus0.slave)
  );

  flash_arbiter #(.FLASH_WIDTH(c_FW), .STARVE_LIMIT(0)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered-read flash models, one per arbiter
  always @(posedge clk) begin
    if (bus0.mem_ce) bus0.mem_d <= flash[bus0.mem_a];
    if (bus1.mem_ce) bus1.mem_d <= flash[bus1.mem_a];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic prev_if;
    logic prev_lpm;
    logic exp_if;
    n_vec = 0;
    n_err = 0;
    for (int i = 0; i < (1 << c_FW); i++) flash[i] = 16'(i * 3 + 16'h0100);
    flash[10'h005] = 16'hBEEF;
    flash[10'h010] = 16'h12AB;

    bus0.mem_d = '0;  bus1.mem_d = '0;
    bus0.if_req = 1'b1; bus0.if_addr = 10'h005; bus0.lpm_req = 1'b0; bus0.lpm_addr = '0;
    bus1.if_req = 1'b0; bus1.if_addr = '0;      bus1.lpm_req = 1'b0; bus1.lpm_addr = '0;
    rst = 1'b1;

    // 1: reset with fetch request pending
    for (int k = 0; k < 3; k++) begin
      tick();
      chk("rst_if_valid", 32'(bus0.if_valid), 32'd0);
      chk("rst_lpm_valid", 32'(bus0.lpm_valid), 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_if_valid", 32'(bus0.if_valid), 32'd0);
    chk("rel_lpm_valid", 32'(bus0.lpm_valid), 32'd0);

    // 2: fetch only
    chk("if_gnt", 32'(bus0.if_gnt), 32'd1);
    chk("if_lpm_gnt", 32'(bus0.lpm_gnt), 32'd0);
    chk("if_mem_ce", 32'(bus0.mem_ce), 32'd1);
    chk("if_mem_a", 32'(bus0.mem_a), 32'h005);
    tick();
    chk("if_valid", 32'(bus0.if_valid), 32'd1);
    chk("if_data", 32'(bus0.if_data), 32'hBEEF);
    bus0.if_req = 1'b0;
    #1;
    chk("idle_mem_ce", 32'(bus0.mem_ce), 32'd0);
    chk("idle_mem_a", 32'(bus0.mem_a), 32'h000);
    tick();
    chk("idle_if_valid", 32'(bus0.if_valid), 32'd0);

    // 3: LPM low then high byte
    bus0.lpm_req = 1'b1; bus0.lpm_addr = 11'h020;
    #1;
    chk("lpm_gnt", 32'(bus0.lpm_gnt), 32'd1);
    chk("lpm_mem_a", 32'(bus0.mem_a), 32'h010);
    tick();
    chk("lpm_valid_lo", 32'(bus0.lpm_valid), 32'd1);
    chk("lpm_data_lo", 32'(bus0.lpm_data), 32'hAB);
    chk("lpm_if_valid", 32'(bus0.if_valid), 32'd0);
    bus0.lpm_addr = 11'h021;
    tick();
    chk("lpm_valid_hi", 32'(bus0.lpm_valid), 32'd1);
    chk("lpm_data_hi", 32'(bus0.lpm_data), 32'h12);
    bus0.lpm_req = 1'b0;
    tick();
    chk("lpm_valid_off", 32'(bus0.lpm_valid), 32'd0);

    // 4: contention, STARVE_LIMIT=3 -> LPM,LPM,LPM,IF repeating
    bus0.if_req = 1'b1;  bus0.if_addr = 10'h005;
    bus0.lpm_req = 1'b1; bus0.lpm_addr = 11'h020;
    #1;
    prev_if = 1'b0; prev_lpm = 1'b0;
    for (int k = 0; k < 9; k++) begin
      exp_if = (k % 4 == 3);
      chk($sformatf("cont_if_gnt[%0d]", k), 32'(bus0.if_gnt), 32'(exp_if));
      chk($sformatf("cont_lpm_gnt[%0d]", k), 32'(bus0.lpm_gnt), 32'(!exp_if));
      tick();
      chk($sformatf("cont_if_valid[%0d]", k), 32'(bus0.if_valid), 32'(exp_if));
      chk($sformatf("cont_lpm_valid[%0d]", k), 32'(bus0.lpm_valid), 32'(!exp_if));
      if (exp_if) chk($sformatf("cont_if_data[%0d]", k), 32'(bus0.if_data), 32'hBEEF);
      else        chk($sformatf("cont_lpm_data[%0d]", k), 32'(bus0.lpm_data), 32'hAB);
      prev_if = exp_if; prev_lpm = !exp_if;
    end
    bus0.if_req = 1'b0; bus0.lpm_req = 1'b0;
    tick();
    chk("cont_end_valid", 32'({bus0.if_valid, bus0.lpm_valid}), 32'd0);

    // 5: STARVE_LIMIT=0 -> fetch strict priority
    bus1.if_req = 1'b1;  bus1.if_addr = 10'h005;
    bus1.lpm_req = 1'b1; bus1.lpm_addr = 11'h021;
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("strict_if_gnt[%0d]", k), 32'(bus1.if_gnt), 32'd1);
      chk($sformatf("strict_lpm_gnt[%0d]", k), 32'(bus1.lpm_gnt), 32'd0);
      tick();
      chk($sformatf("strict_if_valid[%0d]", k), 32'(bus1.if_valid), 32'd1);
      chk($sformatf("strict_lpm_valid[%0d]", k), 32'(bus1.lpm_valid), 32'd0);
    end
    chk("strict_if_data", 32'(bus1.if_data), 32'hBEEF);
    bus1.if_req = 1'b0; bus1.lpm_req = 1'b0;

    // 6: reset while an LPM read is in flight
    bus0.lpm_req = 1'b1; bus0.lpm_addr = 11'h021;
    #1;
    chk("mid_lpm_gnt", 32'(bus0.lpm_gnt), 32'd1);
    #1;
    rst = 1'b1;
    bus0.lpm_req = 1'b0;
    #1;
    chk("mid_rst_lpm_valid", 32'(bus0.lpm_valid), 32'd0);
    tick();
    chk("mid_edge_lpm_valid", 32'(bus0.lpm_valid), 32'd0);
    rst = 1'b0;
    #1;
    chk("mid_rel_valids", 32'({bus0.if_valid, bus0.lpm_valid}), 32'd0);
    chk("mid_rel_owner", 32'(dut0.r_owner), 32'(OWN_NONE));
    tick();
    chk("mid_after_valids", 32'({bus0.if_valid, bus0.lpm_valid}), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

`default_nettype wire
